// File: rtl/program_loader.sv
// Byte-stream boot loader: receives a framed program image, writes it word by word
// into instruction memory and releases the CPU only after the checksum matches.
//
// state  | meaning
// IDLE   | waiting for the start marker after reset
// LENGTH | next byte is the word count N
// DATA   | assembling a word, most significant byte first
// WRITE  | one-cycle memory strobe for the assembled word
// CHECK  | next byte is the checksum
// DONE   | last frame loaded cleanly, CPU released
// ERROR  | last frame failed (bad sum or inter-byte timeout), CPU held
module program_loader #(
   parameter int         INSTRUCTION_WIDTH = 32,
   parameter int         PC_WIDTH          = 8,
   parameter logic [7:0] START_BYTE        = 8'hA5,
   parameter int         TIMEOUT_CYCLES    = 1000
) (
   input  logic                         clock,
   input  logic                         isResetN,
   input  logic [7:0]                   byteData,
   input  logic                         byteValid,
   output logic                         byteReady,
   output logic                         memWriteEnable,
   output logic [PC_WIDTH-1:0]          memAddress,
   output logic [INSTRUCTION_WIDTH-1:0] memData,
   output logic                         cpuHold,
   output logic                         loadDone,
   output logic                         loadError
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LENGTH,
      S_DATA,
      S_WRITE,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   localparam int          BYTES_PER_WORD = INSTRUCTION_WIDTH / 8;
   localparam logic [7:0]  LAST_IDX       = 8'(BYTES_PER_WORD - 1);
   localparam logic [15:0] TIMEOUT_TC     = 16'(TIMEOUT_CYCLES - 1);

   state_t                         r_state;
   state_t                         w_next;
   logic                           r_run;
   logic [7:0]                     r_len;
   logic [7:0]                     r_word_cnt;
   logic [7:0]                     r_byte_idx;
   logic [7:0]                     r_sum;
   logic [15:0]                    r_timer;
   logic [INSTRUCTION_WIDTH-1:0]   r_asm;
   logic [PC_WIDTH-1:0]            r_addr;
   logic                           r_hold;
   logic                           r_done;
   logic                           r_err;

   logic                           w_accept;
   logic                           w_timing;
   logic                           w_timed_out;
   logic                           w_is_start;
   logic [7:0]                     w_word_cnt_inc;

   assign w_accept       = byteValid & byteReady;
   assign w_is_start     = (byteData == START_BYTE);
   assign w_timing       = (r_state == S_LENGTH) || (r_state == S_DATA) || (r_state == S_CHECK);
   assign w_timed_out    = w_timing && !w_accept && (r_timer == TIMEOUT_TC);
   assign w_word_cnt_inc = r_word_cnt + 8'd1;

   assign memAddress = r_addr;
   assign memData    = r_asm;
   assign cpuHold    = r_hold;
   assign loadDone   = r_done;
   assign loadError  = r_err;

   always_ff @(posedge clock or negedge isResetN) begin
      if (!isResetN) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // r_run keeps byteReady low until the first clock edge after reset release
   always_comb begin
      w_next         = r_state;
      byteReady      = r_run && (r_state != S_WRITE);
      memWriteEnable = (r_state == S_WRITE);
      case (r_state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (w_accept && w_is_start) begin
               w_next = S_LENGTH;
            end
         end
         S_LENGTH: begin
            if (w_timed_out) begin
               w_next = S_ERROR;
            end else if (w_accept) begin
               w_next = (byteData == 8'd0) ? S_CHECK : S_DATA;
            end
         end
         S_DATA: begin
            if (w_timed_out) begin
               w_next = S_ERROR;
            end else if (w_accept && (r_byte_idx == LAST_IDX)) begin
               w_next = S_WRITE;
            end
         end
         S_WRITE: begin
            w_next = (w_word_cnt_inc == r_len) ? S_CHECK : S_DATA;
         end
         S_CHECK: begin
            if (w_timed_out) begin
               w_next = S_ERROR;
            end else if (w_accept) begin
               w_next = (byteData == r_sum) ? S_DONE : S_ERROR;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge isResetN) begin
      if (!isResetN) begin
         r_run      <= 1'b0;
         r_len      <= 8'd0;
         r_word_cnt <= 8'd0;
         r_byte_idx <= 8'd0;
         r_sum      <= 8'd0;
         r_timer    <= 16'd0;
         r_asm      <= '0;
         r_addr     <= '0;
         r_hold     <= 1'b1;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_run <= 1'b1;

         // timer only runs while waiting inside a frame; WRITE leaves it frozen
         if (w_accept) begin
            r_timer <= 16'd0;
         end else if (w_timing) begin
            r_timer <= r_timer + 16'd1;
         end

         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (w_accept && w_is_start) begin
                  r_done <= 1'b0;
                  r_err  <= 1'b0;
                  r_hold <= 1'b1;
               end
            end
            S_LENGTH: begin
               if (w_accept) begin
                  r_len      <= byteData;
                  r_sum      <= byteData;
                  r_word_cnt <= 8'd0;
                  r_byte_idx <= 8'd0;
                  r_addr     <= '0;
               end
            end
            S_DATA: begin
               if (w_accept) begin
                  r_asm      <= (r_asm << 8) | INSTRUCTION_WIDTH'(byteData);
                  r_sum      <= r_sum + byteData;
                  r_byte_idx <= (r_byte_idx == LAST_IDX) ? 8'd0 : r_byte_idx + 8'd1;
               end
            end
            S_WRITE: begin
               r_word_cnt <= w_word_cnt_inc;
               r_addr     <= r_addr + 1'b1;
            end
            default: begin
            end
         endcase

         if ((w_next == S_DONE) && (r_state != S_DONE)) begin
            r_done <= 1'b1;
            r_hold <= 1'b0;
         end
         if ((w_next == S_ERROR) && (r_state != S_ERROR)) begin
            r_err <= 1'b1;
         end
      end
   end

endmodule
